// File: rtl/scan_seq_138_pkg.sv
// Shared types and helpers for the ic138 scan sequencer.
package scan138_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // {G1, G2a, G2b} patterns for the active-low 3-to-8 decoder
  localparam logic [2:0] DEC_ON  = 3'b100;
  localparam logic [2:0] DEC_OFF = 3'b011;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_seq_138_if.sv
// Control/status bundle between a scan controller and the ic138 sequencer.
// start/stop are plain levels sampled on every rising edge (no ready/ack);
// all outputs are registered and valid for the whole cycle after an edge.
interface scan_seq_138_if
  import scan138_pkg::*;
#(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         chan_mask;
  logic [2:0]         sel;
  logic               G1;
  logic               G2a;
  logic               G2b;
  logic               busy;
  logic               chan_done;
  logic               frame_done;
  state_t             state;

  modport master (
    output start, stop, dwell, chan_mask,
    input  sel, G1, G2a, G2b, busy, chan_done, frame_done, state
  );

  modport slave (
    input  start, stop, dwell, chan_mask,
    output sel, G1, G2a, G2b, busy, chan_done, frame_done, state
  );
endinterface

// File: rtl/scan_seq_138_next_chan_find.sv
// Finds the next enabled channel above cur; wraps to the lowest enabled one.
module next_chan_find
  import scan138_pkg::*;
(
  input  logic [7:0] mask,
  input  logic [2:0] cur,
  output logic [2:0] nxt,
  output logic       wrap
);
  always_comb begin
    nxt  = lowest_set(mask);
    wrap = 1'b1;
    // Descending scan so the last hit is the closest bit above cur
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (3'(i) > cur)) begin
        nxt  = 3'(i);
        wrap = 1'b0;
      end
    end
  end
endmodule

// File: rtl/scan_seq_138.sv
// Scan sequencer driving ic138 select/enable pins: BLANK gap, then DRIVE for
// dwell cycles, per enabled channel in ascending order.
module scan_seq_138
  import scan138_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  scan_seq_138_if.slave   bus
);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0]      BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [DWELL_W-1:0] ONE        = DWELL_W'(1);

  state_t             state;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;
  logic [BW-1:0]      blank_cnt;
  logic [2:0]         sel_r;
  logic [2:0]         dec_r;
  logic               busy_r;
  logic               chan_done_r;
  logic               frame_done_r;

  logic [2:0]         nxt;
  logic               wrap;
  logic [DWELL_W-1:0] dwell_last;

  next_chan_find u_next (
    .mask (mask_q),
    .cur  (sel_r),
    .nxt  (nxt),
    .wrap (wrap)
  );

  // A dwell of 0 behaves as 1, so the final DRIVE count is max(dwell,1)-1
  assign dwell_last = (dwell_q == '0) ? '0 : (dwell_q - ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask_q       <= '0;
      dwell_q      <= '0;
      cnt          <= '0;
      blank_cnt    <= '0;
      sel_r        <= '0;
      dec_r        <= DEC_OFF;
      busy_r       <= 1'b0;
      chan_done_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      chan_done_r  <= 1'b0;
      frame_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && (bus.chan_mask != 8'h00)) begin
            mask_q    <= bus.chan_mask;
            dwell_q   <= bus.dwell;
            sel_r     <= lowest_set(bus.chan_mask);
            blank_cnt <= '0;
            busy_r    <= 1'b1;
            state     <= BLANK;
          end
        end
        BLANK: begin
          if (bus.stop) begin
            dec_r  <= DEC_OFF;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (blank_cnt == BLANK_LAST) begin
            dec_r        <= DEC_ON;
            cnt          <= '0;
            chan_done_r  <= (dwell_last == '0);
            frame_done_r <= (dwell_last == '0) && wrap;
            state        <= DRIVE;
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end
        DRIVE: begin
          if (bus.stop) begin
            dec_r  <= DEC_OFF;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (cnt == dwell_last) begin
            dec_r     <= DEC_OFF;
            blank_cnt <= '0;
            if (!wrap) begin
              sel_r <= nxt;
              state <= BLANK;
            end else begin
              // Frame boundary: pick up the caller's current mask and dwell
              mask_q  <= bus.chan_mask;
              dwell_q <= bus.dwell;
              if (bus.chan_mask == 8'h00) begin
                busy_r <= 1'b0;
                state  <= IDLE;
              end else begin
                sel_r <= lowest_set(bus.chan_mask);
                state <= BLANK;
              end
            end
          end else begin
            cnt          <= cnt + ONE;
            chan_done_r  <= (cnt == dwell_last - ONE);
            frame_done_r <= (cnt == dwell_last - ONE) && wrap;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel        = sel_r;
  assign bus.G1         = dec_r[2];
  assign bus.G2a        = dec_r[1];
  assign bus.G2b        = dec_r[0];
  assign bus.busy       = busy_r;
  assign bus.chan_done  = chan_done_r;
  assign bus.frame_done = frame_done_r;
  assign bus.state      = state;
endmodule
